// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared RV32I decode constants, ALU/compare codes and decode payload type
package riscv_defs;

  localparam int RV_XLEN = 32;
  localparam int ALUOP_W = 4;

  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALUOP_ADD  = 4'd0;
  localparam aluop_t ALUOP_SUB  = 4'd1;
  localparam aluop_t ALUOP_SLL  = 4'd2;
  localparam aluop_t ALUOP_SLT  = 4'd3;
  localparam aluop_t ALUOP_SLTU = 4'd4;
  localparam aluop_t ALUOP_XOR  = 4'd5;
  localparam aluop_t ALUOP_SRL  = 4'd6;
  localparam aluop_t ALUOP_SRA  = 4'd7;
  localparam aluop_t ALUOP_OR   = 4'd8;
  localparam aluop_t ALUOP_AND  = 4'd9;
  localparam aluop_t ALUOP_MOV  = 4'd10;

  // Compare codes equal the branch funct3 so the decoder can pass funct3 through.
  localparam logic [2:0] ALUCOND_EQ  = 3'b000;
  localparam logic [2:0] ALUCOND_NE  = 3'b001;
  localparam logic [2:0] ALUCOND_LT  = 3'b100;
  localparam logic [2:0] ALUCOND_GE  = 3'b101;
  localparam logic [2:0] ALUCOND_LTU = 3'b110;
  localparam logic [2:0] ALUCOND_GEU = 3'b111;

  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [1:0] OPL_SEL_RS1  = 2'd0;
  localparam logic [1:0] OPL_SEL_PC   = 2'd1;
  localparam logic [1:0] OPL_SEL_ZERO = 2'd2;
  localparam logic       OPR_SEL_RS2  = 1'b0;
  localparam logic       OPR_SEL_IMM  = 1'b1;

  typedef struct packed {
    aluop_t               alu_op;
    logic [2:0]           cmp_op;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic                 rd_we;
    logic [RV_XLEN-1:0]   imm;
    logic [1:0]           opl_sel;
    logic                 opr_sel;
    logic                 branch;
    logic                 jump;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [2:0]           mem_size;
  } dec_t;

  function automatic logic [RV_XLEN-1:0] imm_i(input logic [31:0] ins);
    return {{(RV_XLEN-12){ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_s(input logic [31:0] ins);
    return {{(RV_XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_b(input logic [31:0] ins);
    return {{(RV_XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_u(input logic [31:0] ins);
    return {{(RV_XLEN-32){ins[31]}}, ins[31:12], 12'h000};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_j(input logic [31:0] ins);
    return {{(RV_XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/id_stage_decoder.sv
// rtl/id_stage_decoder.sv - combinational RV32I decode of one instruction word
module id_decoder
  import riscv_defs::*;
(
  input  logic [31:0] ins_i,
  output dec_t        dec_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ins_i[6:0];
  assign funct3 = ins_i[14:12];
  assign funct7 = ins_i[31:25];

  always_comb begin
    dec_o          = '0;
    illegal_o      = 1'b0;
    dec_o.alu_op   = ALUOP_ADD;
    dec_o.opl_sel  = OPL_SEL_RS1;
    dec_o.opr_sel  = OPR_SEL_RS2;
    dec_o.rs1      = ins_i[19:15];
    dec_o.rs2      = ins_i[24:20];
    dec_o.rd       = ins_i[11:7];

    if (ins_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          dec_o.alu_op  = ALUOP_MOV;
          dec_o.opl_sel = OPL_SEL_ZERO;
          dec_o.opr_sel = OPR_SEL_IMM;
          dec_o.imm     = imm_u(ins_i);
          dec_o.rd_we   = 1'b1;
        end
        OPC_AUIPC: begin
          dec_o.opl_sel = OPL_SEL_PC;
          dec_o.opr_sel = OPR_SEL_IMM;
          dec_o.imm     = imm_u(ins_i);
          dec_o.rd_we   = 1'b1;
        end
        OPC_JAL: begin
          dec_o.opl_sel = OPL_SEL_PC;
          dec_o.opr_sel = OPR_SEL_IMM;
          dec_o.imm     = imm_j(ins_i);
          dec_o.jump    = 1'b1;
          dec_o.rd_we   = 1'b1;
        end
        OPC_JALR: begin
          dec_o.opr_sel = OPR_SEL_IMM;
          dec_o.imm     = imm_i(ins_i);
          dec_o.jump    = 1'b1;
          dec_o.rd_we   = 1'b1;
          illegal_o     = (funct3 != 3'b000);
        end
        OPC_BRANCH: begin
          dec_o.cmp_op  = funct3;
          dec_o.opl_sel = OPL_SEL_PC;
          dec_o.opr_sel = OPR_SEL_IMM;
          dec_o.imm     = imm_b(ins_i);
          dec_o.branch  = 1'b1;
          illegal_o     = (funct3 == 3'b010) || (funct3 == 3'b011);
        end
        OPC_LOAD: begin
          dec_o.opr_sel  = OPR_SEL_IMM;
          dec_o.imm      = imm_i(ins_i);
          dec_o.mem_rd   = 1'b1;
          dec_o.mem_size = funct3;
          dec_o.rd_we    = 1'b1;
          illegal_o      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        OPC_STORE: begin
          dec_o.opr_sel  = OPR_SEL_IMM;
          dec_o.imm      = imm_s(ins_i);
          dec_o.mem_wr   = 1'b1;
          dec_o.mem_size = funct3;
          illegal_o      = (funct3 > 3'b010);
        end
        OPC_OP_IMM: begin
          dec_o.opr_sel = OPR_SEL_IMM;
          dec_o.imm     = imm_i(ins_i);
          dec_o.rd_we   = 1'b1;
          case (funct3)
            3'b000: dec_o.alu_op = ALUOP_ADD;
            3'b010: dec_o.alu_op = ALUOP_SLT;
            3'b011: dec_o.alu_op = ALUOP_SLTU;
            3'b100: dec_o.alu_op = ALUOP_XOR;
            3'b110: dec_o.alu_op = ALUOP_OR;
            3'b111: dec_o.alu_op = ALUOP_AND;
            3'b001: begin
              dec_o.alu_op = ALUOP_SLL;
              illegal_o    = (funct7 != 7'h00);
            end
            default: begin
              // ins[30] picks arithmetic vs logical; any other funct7 bit set is reserved.
              dec_o.alu_op = ins_i[30] ? ALUOP_SRA : ALUOP_SRL;
              illegal_o    = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
          endcase
        end
        OPC_OP: begin
          dec_o.rd_we = 1'b1;
          if (funct7 == 7'h00) begin
            case (funct3)
              3'b000:  dec_o.alu_op = ALUOP_ADD;
              3'b001:  dec_o.alu_op = ALUOP_SLL;
              3'b010:  dec_o.alu_op = ALUOP_SLT;
              3'b011:  dec_o.alu_op = ALUOP_SLTU;
              3'b100:  dec_o.alu_op = ALUOP_XOR;
              3'b101:  dec_o.alu_op = ALUOP_SRL;
              3'b110:  dec_o.alu_op = ALUOP_OR;
              default: dec_o.alu_op = ALUOP_AND;
            endcase
          end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
            dec_o.alu_op = ALUOP_SUB;
          end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
            dec_o.alu_op = ALUOP_SRA;
          end else begin
            illegal_o = 1'b1;
          end
        end
        OPC_MISC_MEM: begin
          dec_o.alu_op = ALUOP_ADD;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end

    // Illegal words must not cause side effects downstream.
    if (illegal_o) begin
      dec_o.rd_we  = 1'b0;
      dec_o.mem_rd = 1'b0;
      dec_o.mem_wr = 1'b0;
      dec_o.branch = 1'b0;
      dec_o.jump   = 1'b0;
    end
    if (dec_o.rd == 5'd0) begin
      dec_o.rd_we = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: handshake, flush and registered decode payload
module id_stage
  import riscv_defs::*;
#(
  parameter bit RESET_PC_NOP = 1'b1
) (
  input  logic               clk_i,
  input  logic               resetb_i,
  input  logic               clk_en_i,
  input  logic               ins_valid_i,
  output logic               ins_ready_o,
  input  logic [31:0]        ins_i,
  input  logic [RV_XLEN-1:0] pc_i,
  input  logic               flush_i,
  output logic               ex_valid_o,
  input  logic               ex_ready_i,
  output logic [RV_XLEN-1:0] ex_pc_o,
  output logic [ALUOP_W-1:0] ex_alu_op_o,
  output logic [2:0]         ex_cmp_op_o,
  output logic [4:0]         ex_rs1_o,
  output logic [4:0]         ex_rs2_o,
  output logic [4:0]         ex_rd_o,
  output logic               ex_rd_we_o,
  output logic [RV_XLEN-1:0] ex_imm_o,
  output logic [1:0]         ex_opl_sel_o,
  output logic               ex_opr_sel_o,
  output logic               ex_branch_o,
  output logic               ex_jump_o,
  output logic               ex_mem_rd_o,
  output logic               ex_mem_wr_o,
  output logic [2:0]         ex_mem_size_o,
  output logic               ex_illegal_o
);

  dec_t               dec;
  logic               dec_illegal;
  dec_t               dec_q, dec_d;
  logic [RV_XLEN-1:0] pc_q, pc_d;
  logic               valid_q, valid_d;
  logic               illegal_q, illegal_d;
  logic               capture;

  id_decoder u_decoder (
    .ins_i     (ins_i),
    .dec_o     (dec),
    .illegal_o (dec_illegal)
  );

  assign ins_ready_o = ~valid_q | ex_ready_i;
  assign capture     = clk_en_i & ins_valid_i & ins_ready_o & ~flush_i;

  always_comb begin
    valid_d   = valid_q;
    illegal_d = illegal_q;
    dec_d     = dec_q;
    pc_d      = pc_q;
    if (clk_en_i) begin
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (capture) begin
        valid_d   = 1'b1;
        illegal_d = dec_illegal;
        dec_d     = dec;
        pc_d      = pc_i;
      end else if (ex_ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      if (RESET_PC_NOP) begin
        dec_q <= '0;
        pc_q  <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      dec_q     <= dec_d;
      pc_q      <= pc_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_illegal_o  = illegal_q;
  assign ex_pc_o       = pc_q;
  assign ex_alu_op_o   = dec_q.alu_op;
  assign ex_cmp_op_o   = dec_q.cmp_op;
  assign ex_rs1_o      = dec_q.rs1;
  assign ex_rs2_o      = dec_q.rs2;
  assign ex_rd_o       = dec_q.rd;
  assign ex_rd_we_o    = dec_q.rd_we;
  assign ex_imm_o      = dec_q.imm;
  assign ex_opl_sel_o  = dec_q.opl_sel;
  assign ex_opr_sel_o  = dec_q.opr_sel;
  assign ex_branch_o   = dec_q.branch;
  assign ex_jump_o     = dec_q.jump;
  assign ex_mem_rd_o   = dec_q.mem_rd;
  assign ex_mem_wr_o   = dec_q.mem_wr;
  assign ex_mem_size_o = dec_q.mem_size;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized self-checking bench for id_stage against a reference decode model
module tb_id_stage;
  import riscv_defs::*;

  logic               clk_i = 1'b0;
  logic               resetb_i, clk_en_i, ins_valid_i, flush_i, ex_ready_i;
  logic [31:0]        ins_i;
  logic [RV_XLEN-1:0] pc_i;
  logic               ins_ready_o, ex_valid_o, ex_rd_we_o, ex_opr_sel_o;
  logic               ex_branch_o, ex_jump_o, ex_mem_rd_o, ex_mem_wr_o, ex_illegal_o;
  logic [RV_XLEN-1:0] ex_pc_o, ex_imm_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic [2:0]         ex_cmp_op_o, ex_mem_size_o;
  logic [4:0]         ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [1:0]         ex_opl_sel_o;

  int n_checks = 0;
  int n_errors = 0;

  id_stage #(.RESET_PC_NOP(1'b1)) dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o), .ins_i(ins_i), .pc_i(pc_i),
    .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_pc_o(ex_pc_o), .ex_alu_op_o(ex_alu_op_o), .ex_cmp_op_o(ex_cmp_op_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_rd_we_o(ex_rd_we_o),
    .ex_imm_o(ex_imm_o), .ex_opl_sel_o(ex_opl_sel_o), .ex_opr_sel_o(ex_opr_sel_o),
    .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o), .ex_mem_rd_o(ex_mem_rd_o),
    .ex_mem_wr_o(ex_mem_wr_o), .ex_mem_size_o(ex_mem_size_o), .ex_illegal_o(ex_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        illegal;
    logic [31:0] alu, cmp, imm, opl, opr, size;
    logic        rd_we, branch, jump, mem_rd, mem_wr;
    logic        c_rs1, c_rs2, c_imm, c_opl, c_opr, c_cmp, c_size;
  } exp_t;

  // Model state: what execute should currently be seeing.
  logic        m_valid = 1'b0;
  logic        m_zero  = 1'b0;
  logic [31:0] m_ins   = '0;
  logic [31:0] m_pc    = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (ins 0x%08h)", tag, got, exp, m_ins);
    end
  endtask

  function automatic logic [31:0] sx(input longint v, input int bits);
    longint x;
    x = v;
    if (x >= (longint'(1) << (bits - 1))) x = x - (longint'(1) << bits);
    return x[31:0];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t        e;
    longint      u;
    int unsigned op, f3, f7;
    logic [31:0] rr_alu [8];
    rr_alu = '{ALUOP_ADD, ALUOP_SLL, ALUOP_SLT, ALUOP_SLTU, ALUOP_XOR, ALUOP_SRL, ALUOP_OR, ALUOP_AND};
    u  = longint'(w);
    op = int'(u % 128);
    f3 = int'((u / 4096) % 8);
    f7 = int'(u / 33554432);
    e = '{default: '0};
    e.alu = ALUOP_ADD; e.c_opl = 1; e.c_opr = 1;
    case (op)
      'h37: begin e.alu = ALUOP_MOV; e.c_opl = 0; e.opr = 1; e.imm = w & 32'hFFFFF000; e.c_imm = 1; e.rd_we = 1; end
      'h17: begin e.opl = 1; e.opr = 1; e.imm = w & 32'hFFFFF000; e.c_imm = 1; e.rd_we = 1; end
      'h6F: begin
        e.opl = 1; e.opr = 1; e.jump = 1; e.rd_we = 1; e.c_imm = 1;
        e.imm = sx(((u >> 31) % 2) * (1 << 20) + ((u >> 12) % 256) * (1 << 12)
                   + ((u >> 20) % 2) * (1 << 11) + ((u >> 21) % 1024) * 2, 21);
      end
      'h67: begin e.opr = 1; e.imm = sx(u >> 20, 12); e.c_imm = 1; e.jump = 1; e.rd_we = 1; e.c_rs1 = 1; e.illegal = (f3 != 0); end
      'h63: begin
        e.opl = 1; e.opr = 1; e.branch = 1; e.cmp = f3; e.c_cmp = 1; e.c_rs1 = 1; e.c_rs2 = 1; e.c_imm = 1;
        e.imm = sx(((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048 + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2, 13);
        e.illegal = (f3 == 2 || f3 == 3);
      end
      'h03: begin e.opr = 1; e.imm = sx(u >> 20, 12); e.c_imm = 1; e.mem_rd = 1; e.rd_we = 1; e.size = f3; e.c_size = 1; e.c_rs1 = 1; e.illegal = (f3 == 3 || f3 >= 6); end
      'h23: begin e.opr = 1; e.imm = sx((u >> 25) * 32 + (u >> 7) % 32, 12); e.c_imm = 1; e.mem_wr = 1; e.size = f3; e.c_size = 1; e.c_rs1 = 1; e.c_rs2 = 1; e.illegal = (f3 > 2); end
      'h13: begin
        e.opr = 1; e.imm = sx(u >> 20, 12); e.c_imm = 1; e.rd_we = 1; e.c_rs1 = 1;
        e.alu = rr_alu[f3];
        if (f3 == 1) e.illegal = (f7 != 0);
        if (f3 == 5) begin e.illegal = !(f7 == 0 || f7 == 32); e.alu = (f7 == 32) ? ALUOP_SRA : ALUOP_SRL; end
      end
      'h33: begin
        e.rd_we = 1; e.c_rs1 = 1; e.c_rs2 = 1; e.alu = rr_alu[f3];
        if (f7 == 32 && f3 == 0) e.alu = ALUOP_SUB;
        else if (f7 == 32 && f3 == 5) e.alu = ALUOP_SRA;
        else if (f7 != 0) e.illegal = 1;
      end
      'h0F: begin e.c_opl = 0; e.c_opr = 0; end
      default: e.illegal = 1;
    endcase
    if (u % 4 != 3) e.illegal = 1;
    if (e.illegal) begin e.rd_we = 0; e.mem_rd = 0; e.mem_wr = 0; e.branch = 0; e.jump = 0; end
    if ((u >> 7) % 32 == 0) e.rd_we = 0;
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    check_eq("valid", 32'(ex_valid_o), 32'(m_valid));
    if (m_zero) begin
      check_eq("rst_illegal", 32'(ex_illegal_o), 0);
      check_eq("rst_pc", ex_pc_o, 0);
      check_eq("rst_imm", ex_imm_o, 0);
      check_eq("rst_fields", {ex_alu_op_o, ex_cmp_op_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_mem_size_o}, 0);
      check_eq("rst_flags", {ex_rd_we_o, ex_opl_sel_o, ex_opr_sel_o, ex_branch_o, ex_jump_o, ex_mem_rd_o, ex_mem_wr_o}, 0);
    end else if (m_valid) begin
      e = ref_decode(m_ins);
      check_eq("pc", ex_pc_o, m_pc);
      check_eq("illegal", 32'(ex_illegal_o), 32'(e.illegal));
      check_eq("rd", 32'(ex_rd_o), (m_ins >> 7) % 32);
      check_eq("rd_we", 32'(ex_rd_we_o), 32'(e.rd_we));
      check_eq("ctl", {ex_branch_o, ex_jump_o, ex_mem_rd_o, ex_mem_wr_o}, {e.branch, e.jump, e.mem_rd, e.mem_wr});
      if (!e.illegal) begin
        check_eq("alu_op", 32'(ex_alu_op_o), e.alu);
        if (e.c_opl)  check_eq("opl_sel", 32'(ex_opl_sel_o), e.opl);
        if (e.c_opr)  check_eq("opr_sel", 32'(ex_opr_sel_o), e.opr);
        if (e.c_imm)  check_eq("imm", ex_imm_o, e.imm);
        if (e.c_cmp)  check_eq("cmp_op", 32'(ex_cmp_op_o), e.cmp);
        if (e.c_size) check_eq("mem_size", 32'(ex_mem_size_o), e.size);
        if (e.c_rs1)  check_eq("rs1", 32'(ex_rs1_o), (m_ins >> 15) % 32);
        if (e.c_rs2)  check_eq("rs2", 32'(ex_rs2_o), (m_ins >> 20) % 32);
      end
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic er, input logic fl, input logic ce, input logic rb);
    ins_valid_i = iv; ins_i = ins; pc_i = pc; ex_ready_i = er;
    flush_i = fl; clk_en_i = ce; resetb_i = rb;
    #1;
    check_eq("ins_ready", 32'(ins_ready_o), 32'(!m_valid || er));
    @(posedge clk_i);
    if (!rb) begin
      m_valid = 0; m_zero = 1;
    end else if (ce) begin
      if (fl) m_valid = 0;
      else if (iv && (!m_valid || er)) begin m_valid = 1; m_zero = 0; m_ins = ins; m_pc = pc; end
      else if (m_valid && er) m_valid = 0;
    end
    #1;
    compare_outputs();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    logic [6:0]  ops [11];
    int          k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) w[6:0] = ops[k];
    if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    logic [31:0] held_pc;
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    cycle(1, 32'h00500093, 32'h100, 1, 0, 1, 1);
    check_eq("addi_imm", ex_imm_o, 32'd5);
    check_eq("addi_alu", 32'(ex_alu_op_o), ALUOP_ADD);
    check_eq("addi_sel", {ex_opl_sel_o, ex_opr_sel_o, ex_rd_o, ex_rd_we_o}, {2'd0, 1'b1, 5'd1, 1'b1});
    cycle(1, 32'h402081B3, 32'h104, 1, 0, 1, 1);
    check_eq("sub_alu", 32'(ex_alu_op_o), ALUOP_SUB);
    check_eq("sub_regs", {ex_rs1_o, ex_rs2_o, ex_rd_o}, {5'd1, 5'd2, 5'd3});
    cycle(1, 32'h40335293, 32'h108, 1, 0, 1, 1);
    check_eq("srai_alu", 32'(ex_alu_op_o), ALUOP_SRA);
    check_eq("srai_imm", ex_imm_o, 32'h403);
    cycle(1, 32'hFE209CE3, 32'h10C, 1, 0, 1, 1);
    check_eq("bne_ctl", {ex_branch_o, ex_cmp_op_o, ex_opl_sel_o, ex_rd_we_o}, {1'b1, 3'b001, 2'd1, 1'b0});
    check_eq("bne_imm", ex_imm_o, 32'hFFFFFFF8);
    cycle(1, 32'h00000000, 32'h110, 1, 0, 1, 1);
    check_eq("zero_ill", {ex_illegal_o, ex_rd_we_o, ex_mem_rd_o, ex_mem_wr_o}, {1'b1, 3'b000});
    cycle(1, 32'h00000073, 32'h114, 1, 0, 1, 1);
    check_eq("ecall_ill", {ex_illegal_o, ex_rd_we_o, ex_mem_rd_o, ex_mem_wr_o}, {1'b1, 3'b000});
    cycle(1, 32'h00000013, 32'h118, 1, 0, 1, 1);
    check_eq("nop_x0", {ex_illegal_o, ex_rd_we_o}, 0);

    held_pc = ex_pc_o;
    for (int i = 0; i < 3; i++) cycle(1, 32'h002081B3, 32'h11C, 0, 0, 1, 1);
    check_eq("stall_pc", ex_pc_o, 32'h118);
    cycle(1, 32'h002081B3, 32'h11C, 1, 0, 1, 1);
    check_eq("release_pc", ex_pc_o, 32'h11C);

    cycle(1, 32'h00100093, 32'h120, 1, 1, 1, 1);
    check_eq("flush_valid", 32'(ex_valid_o), 0);
    cycle(1, 32'h00100093, 32'h124, 1, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0, 1);
    check_eq("flush_gated", 32'(ex_valid_o), 1);

    cycle(1, 32'h00C00113, 32'h128, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check_eq("rst_stall", 32'(ex_valid_o), 0);
    cycle(1, 32'h00700193, 32'h12C, 1, 0, 1, 1);
    check_eq("post_rst_imm", ex_imm_o, 32'd7);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_ins(), $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) != 0, $urandom_range(0, 99) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
